// File: rtl/dd_pkg.sv
// Shared types and width constants for the N-channel hash distributor.
// A tuple travels through the crossbar as one packed record.
package dd_pkg;

  localparam int DD_DATA_W   = 64;
  localparam int DD_TAG_W    = 32;
  localparam int DD_SERIAL_W = 64;

  typedef struct packed {
    logic [DD_DATA_W-1:0]   data;
    logic [DD_TAG_W-1:0]    tag;
    logic                   last_processed;
    logic [DD_SERIAL_W-1:0] serialnum;
    logic                   was_joined;
  } tuple_t;

  // Occupancy counter width for a FIFO holding 0..depth entries.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the registered pointer and ascends,
// wrapping modulo N; after a grant to i the pointer moves to i+1.
module rr_arbiter #(
  parameter int N = 8,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        ptr_d      = idx + PTR_W'(1);
        found      = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment and reset asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dd_n_xbar.sv
// Single-stage N-way hash distributor: each input is routed by LOG2_N tag bits
// to one output, where a round-robin arbiter feeds a small FIFO.
module dd_n_xbar
  import dd_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int INPUT_SIZE   = DD_DATA_W,
  parameter int DECISION_BIT = 0,
  parameter int FIFO_DEPTH   = 4,
  localparam int LOG2_N = $clog2(N_CH),
  localparam int LVL_W  = level_width(FIFO_DEPTH),
  localparam int PTR_W  = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [INPUT_SIZE-1:0]   in_data [N_CH],
  input  logic [DD_TAG_W-1:0]     in_tag [N_CH],
  input  logic [N_CH-1:0]         in_last_processed,
  input  logic [DD_SERIAL_W-1:0]  in_serialnum [N_CH],
  input  logic [N_CH-1:0]         in_was_joined,
  input  logic [N_CH-1:0]         out_ready,
  output logic [N_CH-1:0]         out_valid,
  output logic [INPUT_SIZE-1:0]   out_data [N_CH],
  output logic [DD_TAG_W-1:0]     out_tag [N_CH],
  output logic [N_CH-1:0]         out_last_processed,
  output logic [DD_SERIAL_W-1:0]  out_serialnum [N_CH],
  output logic [N_CH-1:0]         out_was_joined,
  output logic [LVL_W-1:0]        out_level [N_CH]
);

  tuple_t          in_tuple [N_CH];
  logic [N_CH-1:0] req      [N_CH];
  logic [N_CH-1:0] grant    [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      in_tuple[i].data           = in_data[i];
      in_tuple[i].tag            = in_tag[i];
      in_tuple[i].last_processed = in_last_processed[i];
      in_tuple[i].serialnum      = in_serialnum[i];
      in_tuple[i].was_joined     = in_was_joined[i];
    end
  end

  always_comb begin
    for (int o = 0; o < N_CH; o++) begin
      for (int i = 0; i < N_CH; i++) begin
        req[o][i] = in_valid[i] &&
                    (in_tag[i][DECISION_BIT +: LOG2_N] == LOG2_N'(o));
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < N_CH; o++) in_ready = in_ready | grant[o];
  end

  for (genvar o = 0; o < N_CH; o++) begin : g_out
    tuple_t           mem [FIFO_DEPTH];
    tuple_t           head;
    tuple_t           push_tuple;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, push, pop;

    assign full = (level_q == LVL_W'(FIFO_DEPTH));
    assign push = |grant[o];
    assign pop  = out_valid[o] && out_ready[o];

    // Fullness uses the registered level only, keeping out_ready off the in_ready path;
    // resetn gates the grant so nothing is acknowledged while in reset.
    rr_arbiter #(.N(N_CH)) u_arb (
      .clk    (clk),
      .resetn (resetn),
      .req    (req[o]),
      .enable (!full && resetn),
      .grant  (grant[o])
    );

    always_comb begin
      push_tuple = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (grant[o][i]) push_tuple = in_tuple[i];
      end
    end

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end

    // NOTE: storage is not reset; outputs are zero-gated while empty instead.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_tuple;
    end

    assign head                  = mem[rd_ptr_q];
    assign out_valid[o]          = (level_q != '0);
    assign out_level[o]          = level_q;
    assign out_data[o]           = out_valid[o] ? head.data      : '0;
    assign out_tag[o]            = out_valid[o] ? head.tag       : '0;
    assign out_last_processed[o] = out_valid[o] && head.last_processed;
    assign out_serialnum[o]      = out_valid[o] ? head.serialnum : '0;
    assign out_was_joined[o]     = out_valid[o] && head.was_joined;
  end

endmodule
